// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch sequencer states.
    //   BOOT  : one idle cycle after reset, no request issued.
    //   RUN   : normal sequential fetching.
    //   FLUSH : one-cycle flush pulse to memory after a redirect.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // One instruction buffer entry: the fetched word and the PC it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Size of one instruction word in bytes; the PC advances by this amount.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Force a byte address onto a word boundary (low address bits cleared).
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries used as the instruction buffer.
// Pointers wrap naturally; count carries one extra bit so full and empty
// are distinguishable. Push when full and pop when empty are ignored.
// Clear empties the buffer and takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  fetch_entry_t              push_data_i,
    input  logic                      pop_i,
    input  logic                      clear_i,
    output fetch_entry_t              head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Qualify requests: never write a full buffer or read an empty one.
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i  && !empty_o && !clear_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : fetch_fifo

// File: rtl/instr_fetch_stage.sv
// Front-end fetch stage: owns the PC, issues sequential word fetches to
// instruction memory (at most one outstanding), buffers returned words with
// their PCs and presents them to decode. A redirect from execute squashes
// all wrong-path state and pulses a flush to memory.
//
// Handshakes (both use the same rule): a transfer happens on a rising edge
// where the producer's valid and the consumer's ready are both high. Valid
// never depends on ready, and while valid is high and ready is low the
// presented payload holds stable.
//   memory : valid = instr_mem_en_o, ready = instr_ready_i,
//            payload = instr_mem_address_o; the word returns on
//            instr_mem_read_i exactly one cycle after acceptance.
//   decode : valid = instr_valid_o, ready = instr_ready_i_dec,
//            payload = instr_o / instr_pc_o.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_ready_i,
    output logic        instr_mem_en_o,
    output logic [31:0] instr_mem_address_o,
    input  logic [31:0] instr_mem_read_i,
    output logic        instr_mem_flush_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i_dec
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Sequencer state
    fetch_state_t  state_q, state_d;

    // Fetch datapath state
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q, req_pc_d;

    // Control
    logic          redirect_take;
    logic          credit_ok;
    logic          fetch_en;
    logic          flush_pulse;
    logic          req_accept;

    // Instruction buffer interface
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_clear;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_head;

    // A redirect is honoured in every state except the post-reset idle cycle.
    assign redirect_take = redirect_i && (state_q != BOOT);

    // Credit check: buffered entries plus the outstanding request must leave
    // room, so a returning word always has a slot to land in.
    assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight_q))
                       < (CW+1)'(FIFO_DEPTH);

    // Sequencer next state and its control outputs.
    always_comb begin
        state_d     = state_q;
        fetch_en    = 1'b0;
        flush_pulse = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                fetch_en = credit_ok && !redirect_i;
            end
            FLUSH: begin
                flush_pulse = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (redirect_take) begin
            state_d = FLUSH;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Request acceptance does not feed back into fetch_en, keeping en
    // independent of the memory's ready.
    assign req_accept = fetch_en && instr_ready_i;

    // PC and outstanding-request tracking; redirect overrides everything.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = 1'b0;
        req_pc_d   = req_pc_q;
        if (redirect_take) begin
            pc_d       = word_align(redirect_pc_i);
            inflight_d = 1'b0;
        end else if (req_accept) begin
            pc_d       = pc_q + INSTR_BYTES;
            inflight_d = 1'b1;
            req_pc_d   = pc_q;
        end
    end

    // PC and outstanding-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // The word on the read bus belongs to the request accepted last cycle.
    // A redirect in the same cycle discards it and voids any decode pop.
    assign fifo_wdata.instr = instr_mem_read_i;
    assign fifo_wdata.pc    = req_pc_q;
    assign fifo_push        = inflight_q && !redirect_take && !fifo_full;
    assign fifo_pop         = instr_ready_i_dec && !redirect_take;
    assign fifo_clear       = redirect_take;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .clear_i     (fifo_clear),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Memory side
    assign instr_mem_en_o      = fetch_en;
    assign instr_mem_address_o = pc_q;
    assign instr_mem_flush_o   = flush_pulse;

    // Decode side; payload reads as zero while nothing is buffered so stale
    // storage never leaks out after reset or a squash.
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? 32'h0 : fifo_head.instr;
    assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed steps plus a randomized run, with a
// queue-based reference model of the fetch stage's observable behaviour.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        instr_ready_i;
  logic        instr_mem_en_o;
  logic [31:0] instr_mem_address_o;
  logic [31:0] instr_mem_read_i;
  logic        instr_mem_flush_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i_dec;

  instr_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_ready_i       (instr_ready_i),
    .instr_mem_en_o      (instr_mem_en_o),
    .instr_mem_address_o (instr_mem_address_o),
    .instr_mem_read_i    (instr_mem_read_i),
    .instr_mem_flush_o   (instr_mem_flush_o),
    .redirect_i          (redirect_i),
    .redirect_pc_i       (redirect_pc_i),
    .instr_valid_o       (instr_valid_o),
    .instr_o             (instr_o),
    .instr_pc_o          (instr_pc_o),
    .instr_ready_i_dec   (instr_ready_i_dec)
  );

  // ---------------- counters ----------------
  int cmp_cnt = 0;
  int mis_cnt = 0;

  // ---------------- reference model ----------------
  // Expected buffer contents, oldest first: {instr, pc}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;         // next address to request
  logic        m_pend;       // a request was accepted last cycle
  logic [31:0] m_pend_pc;    // address of that request
  logic [31:0] m_pend_word;  // word memory returns for it
  logic        m_boot;       // first cycle after reset: no fetch
  logic        m_flush;      // cycle after a redirect: flush pulse

  task automatic model_reset();
    exp_q.delete();
    m_pc        = RESET_PC;
    m_pend      = 1'b0;
    m_pend_pc   = 32'h0;
    m_pend_word = 32'h0;
    m_boot      = 1'b1;
    m_flush     = 1'b0;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Drives inputs just after a rising edge, checks outputs at the falling
  // edge against the model, then advances the model to the next edge.
  task automatic cycle(input logic r, input logic rdy, input logic dec,
                       input logic redir, input logic [31:0] rpc);
    logic        exp_en;
    logic        exp_valid;
    logic [63:0] head;
    rst               = r;
    instr_ready_i     = rdy;
    instr_ready_i_dec = dec;
    redirect_i        = redir;
    redirect_pc_i     = rpc;
    instr_mem_read_i  = m_pend ? m_pend_word : $urandom;
    @(negedge clk);

    exp_en    = !m_boot && !m_flush && !redir && ((exp_q.size() + (m_pend ? 1 : 0)) < DEPTH);
    exp_valid = (exp_q.size() != 0);
    head      = exp_valid ? exp_q[0] : 64'h0;

    check("en",       {31'h0, instr_mem_en_o},    {31'h0, exp_en});
    check("addr",     instr_mem_address_o,        m_pc);
    check("flush",    {31'h0, instr_mem_flush_o}, {31'h0, m_flush});
    check("valid",    {31'h0, instr_valid_o},     {31'h0, exp_valid});
    check("instr",    instr_o,                    head[63:32]);
    check("instr_pc", instr_pc_o,                 head[31:0]);

    if (r) begin
      model_reset();
    end else if (redir && !m_boot) begin
      exp_q.delete();
      m_pc    = rpc & 32'hFFFF_FFFC;
      m_pend  = 1'b0;
      m_boot  = 1'b0;
      m_flush = 1'b1;
    end else begin
      if (exp_valid && dec) begin
        void'(exp_q.pop_front());
      end
      if (m_pend) begin
        exp_q.push_back({m_pend_word, m_pend_pc});
      end
      if (exp_en && rdy) begin
        m_pend      = 1'b1;
        m_pend_pc   = m_pc;
        m_pend_word = $urandom;
        m_pc        = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
      m_boot  = 1'b0;
      m_flush = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_r, r_redir, r_rdy, r_dec;
    logic [31:0] r_pc;

    rst               = 1'b1;
    instr_ready_i     = 1'b0;
    instr_ready_i_dec = 1'b0;
    redirect_i        = 1'b0;
    redirect_pc_i     = 32'h0;
    instr_mem_read_i  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state held, then free-running fetch with both readies high.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalled: buffer fills, fetch stops; then drain and resume.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Memory not ready for 3 cycles while pc = 0x8.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to an unaligned target while a response is pending.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect, then a second redirect during the flush cycle.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0302);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap past the top of the address space.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-stream with a request in flight.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_r     = ($urandom_range(0, 99) == 0);
      r_redir = !r_r && ($urandom_range(0, 15) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_dec   = ($urandom_range(0, 2) != 0);
      r_pc    = $urandom;
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cycle(r_r, r_rdy, r_dec, r_redir, r_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule : tb_instr_fetch_stage
